cdb_arbiter: RTL and testbench

//  Shares the common data bus lanes between functional-unit result producers (ALU, branch, LSU, mul/div).

---
 rtl/cdb_arbiter.sv | 152 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter that moves up to N_LANES producer results
// per cycle onto the registered common data bus lanes.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   flush_i       pipeline flush: no grants this cycle, lanes empty next cycle
//   req_vld_i     per-producer result valid
//   req_rdy_o     per-producer grant (combinational, same cycle)
//   req_data_i    per-producer result value
//   req_rob_i     per-producer destination ROB tag
//   lane_vld_o    per-lane valid, one cycle after the grant
//   lane_data_o   per-lane data (0 when the lane is empty)
//   lane_rob_o    per-lane ROB tag (0 when the lane is empty)
//   perf_stall_o  per-producer saturating count of cycles spent valid but not
//                 granted; exists only when CDB_ARB_PERF_EN is defined
//
// Build option: define CDB_ARB_PERF_EN to add the stall counters.

// One CDB lane output register; data and tag are zeroed when the lane is empty.
module cdb_lane #(
    parameter int WIDTH     = 32,
    parameter int ROB_IDX_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [ROB_IDX_W-1:0] in_rob,
    output logic                 lane_vld,
    output logic [WIDTH-1:0]     lane_data,
    output logic [ROB_IDX_W-1:0] lane_rob
);
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_vld  <= 1'b0;
            lane_data <= '0;
            lane_rob  <= '0;
        end else begin
            lane_vld  <= in_vld;
            lane_data <= in_vld ? in_data : '0;
            lane_rob  <= in_vld ? in_rob  : '0;
        end
    end
endmodule

module cdb_arbiter #(
    parameter int N_REQ     = 4,
    parameter int N_LANES   = 2,
    parameter int WIDTH     = 32,
    parameter int ROB_IDX_W = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush_i,
    input  logic [N_REQ-1:0]                    req_vld_i,
    output logic [N_REQ-1:0]                    req_rdy_o,
    input  logic [N_REQ-1:0][WIDTH-1:0]         req_data_i,
    input  logic [N_REQ-1:0][ROB_IDX_W-1:0]     req_rob_i,
    output logic [N_LANES-1:0]                  lane_vld_o,
    output logic [N_LANES-1:0][WIDTH-1:0]       lane_data_o,
    output logic [N_LANES-1:0][ROB_IDX_W-1:0]   lane_rob_o
`ifdef CDB_ARB_PERF_EN
   ,output logic [N_REQ-1:0][15:0]              perf_stall_o
`endif
);
    localparam int PW = $clog2(N_REQ);
    localparam logic [PW:0]   NR   = (PW+1)'(N_REQ);
    localparam logic [PW-1:0] LAST = PW'(N_REQ - 1);

    logic [PW-1:0]                rr_ptr;
    logic [N_REQ-1:0][PW-1:0]     scan_idx;   // requester visited at scan step o
    logic [N_REQ-1:0]             grant;
    logic [N_LANES-1:0]           sel_vld;
    logic [N_LANES-1:0][PW-1:0]   sel_idx;    // requester feeding lane k
    logic [PW-1:0]                last_idx;
    logic                         placed;

    // scan_idx[o] = (rr_ptr + o) mod N_REQ; the sum is below 2*N_REQ so one
    // conditional subtract is enough.
    for (genvar o = 0; o < N_REQ; o++) begin : g_scan
        localparam logic [PW:0] OFS = (PW+1)'(o);
        logic [PW:0] sum;
        assign sum         = {1'b0, rr_ptr} + OFS;
        assign scan_idx[o] = (sum >= NR) ? PW'(sum - NR) : sum[PW-1:0];
    end

    // Walk requesters in round-robin order; each valid one takes the lowest
    // free lane until the lanes run out. Flush and reset suppress all grants.
    always_comb begin
        grant    = '0;
        sel_vld  = '0;
        sel_idx  = '0;
        last_idx = rr_ptr;
        placed   = 1'b0;
        for (int o = 0; o < N_REQ; o++) begin
            placed = 1'b0;
            if (req_vld_i[scan_idx[o]] && !flush_i && !rst) begin
                for (int k = 0; k < N_LANES; k++) begin
                    if (!sel_vld[k] && !placed) begin
                        sel_vld[k] = 1'b1;
                        sel_idx[k] = scan_idx[o];
                        placed     = 1'b1;
                    end
                end
                if (placed) begin
                    grant[scan_idx[o]] = 1'b1;
                    last_idx           = scan_idx[o];
                end
            end
        end
    end

    assign req_rdy_o = grant;

    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (|grant)
            rr_ptr <= (last_idx == LAST) ? '0 : last_idx + PW'(1);
    end

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        cdb_lane #(
            .WIDTH     (WIDTH),
            .ROB_IDX_W (ROB_IDX_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .in_vld    (sel_vld[k]),
            .in_data   (req_data_i[sel_idx[k]]),
            .in_rob    (req_rob_i[sel_idx[k]]),
            .lane_vld  (lane_vld_o[k]),
            .lane_data (lane_data_o[k]),
            .lane_rob  (lane_rob_o[k])
        );
    end

`ifdef CDB_ARB_PERF_EN
    // Stall counters survive flushes; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_o <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_vld_i[i] && !req_rdy_o[i] && perf_stall_o[i] != 16'hFFFF)
                    perf_stall_o[i] <= perf_stall_o[i] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
    localparam int N_REQ     = 4;
    localparam int N_LANES   = 2;
    localparam int WIDTH     = 32;
    localparam int ROB_IDX_W = 3;

    logic clk = 1'b0;
    logic rst, flush_i;
    logic [N_REQ-1:0]                  req_vld_i, req_rdy_o;
    logic [N_REQ-1:0][WIDTH-1:0]       req_data_i;
    logic [N_REQ-1:0][ROB_IDX_W-1:0]   req_rob_i;
    logic [N_LANES-1:0]                lane_vld_o;
    logic [N_LANES-1:0][WIDTH-1:0]     lane_data_o;
    logic [N_LANES-1:0][ROB_IDX_W-1:0] lane_rob_o;
`ifdef CDB_ARB_PERF_EN
    logic [N_REQ-1:0][15:0]            perf_stall_o;
`endif

    always #5 clk = ~clk;

    cdb_arbiter #(.N_REQ(N_REQ), .N_LANES(N_LANES), .WIDTH(WIDTH), .ROB_IDX_W(ROB_IDX_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .req_vld_i   (req_vld_i),
        .req_rdy_o   (req_rdy_o),
        .req_data_i  (req_data_i),
        .req_rob_i   (req_rob_i),
        .lane_vld_o  (lane_vld_o),
        .lane_data_o (lane_data_o),
        .lane_rob_o  (lane_rob_o)
`ifdef CDB_ARB_PERF_EN
       ,.perf_stall_o(perf_stall_o)
`endif
    );

    typedef struct {
        logic [N_LANES-1:0]                vld;
        logic [N_LANES-1:0][WIDTH-1:0]     data;
        logic [N_LANES-1:0][ROB_IDX_W-1:0] rob;
    } lane_t;

    lane_t              lane_q[$];
    logic [N_REQ-1:0]   rdy_q[$];
    int checks = 0, failures = 0;

    // Producer state and reference round-robin pointer.
    bit                   pend [N_REQ];
    logic [WIDTH-1:0]     pdat [N_REQ];
    logic [ROB_IDX_W-1:0] prob [N_REQ];
    int                   ptr = 0;

    task automatic new_result(input int i);
        pend[i] = 1'b1;
        pdat[i] = $urandom;
        prob[i] = ROB_IDX_W'($urandom_range(0, (1 << ROB_IDX_W) - 1));
    endtask

    // One cycle: drive inputs, predict grants and next-cycle lanes, advance.
    // mode 0: directed (no new arrivals), 1: re-arm every granted producer,
    // 2: random arrivals and random withdrawals after a flush.
    task automatic step(input bit r, input bit f, input int mode);
        logic [N_REQ-1:0] g;
        lane_t e;
        int cnt, last, i;
        if (mode == 2)
            for (int k = 0; k < N_REQ; k++)
                if (!pend[k] && $urandom_range(0, 1) == 1) new_result(k);
        rst = r;
        flush_i = f;
        for (int k = 0; k < N_REQ; k++) begin
            req_vld_i[k]  = pend[k];
            req_data_i[k] = pdat[k];
            req_rob_i[k]  = prob[k];
        end
        g = '0;
        e.vld = '0; e.data = '0; e.rob = '0;
        cnt = 0; last = 0;
        if (r) begin
            ptr = 0;
        end else if (!f) begin
            for (int o = 0; o < N_REQ; o++) begin
                i = (ptr + o) % N_REQ;
                if (pend[i] && cnt < N_LANES) begin
                    g[i] = 1'b1;
                    e.vld[cnt]  = 1'b1;
                    e.data[cnt] = pdat[i];
                    e.rob[cnt]  = prob[i];
                    cnt++;
                    last = i;
                end
            end
            if (cnt > 0) ptr = (last + 1) % N_REQ;
        end
        rdy_q.push_back(g);
        lane_q.push_back(e);
        @(posedge clk);
        #1;
        for (int k = 0; k < N_REQ; k++) begin
            if (g[k]) begin
                pend[k] = 1'b0;
                if (mode == 1) new_result(k);
            end
            if (f && mode == 2 && pend[k] && $urandom_range(0, 1) == 1) pend[k] = 1'b0;
        end
    endtask

    // Monitor: checks grants and lane contents every cycle against the queues.
    initial begin
        lane_t e;
        logic [N_REQ-1:0] g;
        forever begin
            @(negedge clk);
            if (rdy_q.size() > 0) begin
                g = rdy_q.pop_front();
                checks++;
                if (req_rdy_o !== g) begin
                    failures++;
                    $display("FAIL rdy t=%0t got=%b exp=%b", $time, req_rdy_o, g);
                end
            end
            if (lane_q.size() > 0) begin
                e = lane_q.pop_front();
                checks++;
                if (lane_vld_o !== e.vld || lane_data_o !== e.data || lane_rob_o !== e.rob) begin
                    failures++;
                    $display("FAIL lanes t=%0t got vld=%b data=%h rob=%h exp vld=%b data=%h rob=%h",
                             $time, lane_vld_o, lane_data_o, lane_rob_o, e.vld, e.data, e.rob);
                end
            end
        end
    end

    initial begin
        lane_t z;
        rst = 1'b1;
        flush_i = 1'b0;
        req_vld_i = '0; req_data_i = '0; req_rob_i = '0;
        for (int k = 0; k < N_REQ; k++) new_result(k);
        @(posedge clk);
        #1;
        // Registers are reset after the first edge; lanes start empty.
        z.vld = '0; z.data = '0; z.rob = '0;
        lane_q.push_back(z);

        // Reset with everything valid, then first grants 0 and 1, then 2 and 3.
        step(1, 0, 0); step(1, 0, 0);
        step(0, 0, 0); step(0, 0, 0);

        // Continuously valid: {0,1},{2,3},{0,1},{2,3}, then drain.
        for (int k = 0; k < N_REQ; k++) new_result(k);
        repeat (4) step(0, 0, 1);
        step(0, 0, 0); step(0, 0, 0);

        // Single request on 2 -> lane 0, pointer moves to 3.
        pend[2] = 1'b1; pdat[2] = 32'hDEAD_BEEF; prob[2] = 3'd5;
        step(0, 0, 0);

        // Wrap-around: 3 takes lane 0, 0 takes lane 1, pointer -> 1.
        new_result(3); new_result(0);
        step(0, 0, 0);

        // Flush while 1 is valid: no grant, empty lanes next; granted afterwards.
        new_result(1);
        step(0, 1, 0);
        step(0, 0, 0);

        // Reset mid-operation restarts the pointer at 0.
        for (int k = 0; k < N_REQ; k++) new_result(k);
        step(0, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0); step(0, 0, 0);

        // Random traffic with occasional flushes and resets.
        for (int c = 0; c < 3000; c++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 11) == 0, 2);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
